// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (normal, non-show-ahead mode).
// Full/empty/almost-full are registered from the next occupancy count.
module sync_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned AF_LEVEL = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic [CNT_W-1:0]  usedw_nxt_c;

  // Accept decisions from registered flags, and the resulting occupancy
  always_comb begin
    wr_acc_c    = wr_req & ~full;
    rd_acc_c    = rd_req & ~empty;
    usedw_nxt_c = usedw;
    if (wr_acc_c && !rd_acc_c) begin
      usedw_nxt_c = usedw + CNT_W'(1);
    end else if (!wr_acc_c && rd_acc_c) begin
      usedw_nxt_c = usedw - CNT_W'(1);
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, read data, count, flags and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      usedw       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc_c) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
      end
      rd_valid    <= rd_acc_c;
      usedw       <= usedw_nxt_c;
      full        <= (usedw_nxt_c == CNT_W'(DEPTH));
      empty       <= (usedw_nxt_c == '0);
      almost_full <= (usedw_nxt_c >= CNT_W'(AF_LEVEL));
      overflow    <= wr_req & full;
      underflow   <= rd_req & empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: occupancy model plus a queue of expected read data.
module tb_sync_fifo;

  localparam int DEPTH = 256;
  localparam int AF    = 240;

  logic       clk;
  logic       rst_n;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [8:0] usedw;
  logic       overflow;
  logic       underflow;

  sync_fifo #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .AF_LEVEL(AF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .usedw      (usedw),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cnt      = 0;
  logic [7:0] sb [$];
  logic [7:0] last_rd  = 8'h00;
  int         rv_cnt;
  int         uf_cnt;
  int         of_cnt;

  // Single comparison point: counts and reports
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_usedw"}, usedw, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_underflow"}, underflow, 0);
  endtask

  // One clock of stimulus; model updated before the edge, DUT checked 1ns after it
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    logic wa, ra, exp_of, exp_uf;
    wr_req  = w;
    wr_data = d;
    rd_req  = r;
    exp_of  = w && (cnt == DEPTH);
    exp_uf  = r && (cnt == 0);
    wa      = w && (cnt != DEPTH);
    ra      = r && (cnt != 0);
    if (ra) last_rd = sb.pop_front();
    if (wa) sb.push_back(d);
    if (wa && !ra) cnt++;
    else if (ra && !wa) cnt--;
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, ra);
    chk("rd_data", rd_data, last_rd);
    chk("usedw", usedw, cnt);
    chk("full", full, cnt == DEPTH);
    chk("empty", empty, cnt == 0);
    chk("almost_full", almost_full, cnt >= AF);
    chk("overflow", overflow, exp_of);
    chk("underflow", underflow, exp_uf);
    if (rd_valid) rv_cnt++;
    if (underflow) uf_cnt++;
    if (overflow) of_cnt++;
  endtask

  task automatic idle();
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    int wr_done;
    logic w, r;
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Fill with 0x00..0xFF
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 0) chk("empty_drop", empty, 0);
      if (i == AF - 2) chk("af_before", almost_full, 0);
      if (i == AF - 1) chk("af_rise", almost_full, 1);
    end
    chk("full_after_fill", full, 1);
    chk("usedw_after_fill", usedw, DEPTH);

    // Overflow for 3 cycles with 0xAA
    of_cnt = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hAA, 1'b0);
    chk("overflow_cycles", of_cnt, 3);
    chk("usedw_hold_full", usedw, DEPTH);

    // Drain 258 cycles
    rv_cnt = 0;
    uf_cnt = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (i < DEPTH) chk("drain_order", rd_data, i);
    end
    chk("drain_valid_cycles", rv_cnt, DEPTH);
    chk("drain_underflows", uf_cnt, 2);
    chk("empty_after_drain", empty, 1);

    // Simultaneous read/write at usedw=10
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b1);
      chk("steady_usedw", usedw, 10);
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);

    // Empty edge: both requested
    cyc(1'b1, 8'h5A, 1'b1);
    chk("empty_both_uf", underflow, 1);
    chk("empty_both_usedw", usedw, 1);
    chk("empty_both_no_bypass", rd_valid, 0);

    // Full edge: both requested
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 8'(i * 3), 1'b0);
    chk("refill_full", full, 1);
    cyc(1'b1, 8'hC3, 1'b1);
    chk("full_both_of", overflow, 1);
    chk("full_both_usedw", usedw, DEPTH - 1);
    chk("full_both_rd", rd_valid, 1);
    for (int i = 0; i < DEPTH && cnt > 0; i++) cyc(1'b0, 8'h00, 1'b1);

    // Random stream of 600 accepted writes across pointer wraps
    wr_done = 0;
    for (int it = 0; it < 6000 && wr_done < 600; it++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      if (w && cnt != DEPTH) wr_done++;
      cyc(w, 8'($urandom_range(0, 255)), r);
    end
    chk("stream_writes", wr_done, 600);
    for (int i = 0; i < DEPTH + 1 && cnt > 0; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("stream_drained", usedw, 0);
    chk("stream_sb_empty", sb.size(), 0);

    // Reset mid-operation at usedw=37
    for (int i = 0; i < 37; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0);
    chk("pre_reset_usedw", usedw, 37);
    idle();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    cnt = 0;
    sb.delete();
    last_rd = 8'h00;
    @(posedge clk);
    #1;
    chk_reset_vals("held_reset");
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_reset_uf", underflow, 1);
    chk("post_reset_rv", rd_valid, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock FIFO buffer that sits on the responder side of the writer/reader request interface used by `fifo_wr` and `fifo_rd`. It accepts `wr_req`/`wr_data` from a producer, returns `rd_data` to a consumer on `rd_req`, and reports the full, empty, almost-full and used-word status those blocks act on. It is for same-clock-domain paths where a dual-clock FIFO is unnecessary. Storage is an inferred register/RAM array with registered read data: one cycle of latency, normal (non-show-ahead) mode.

## Interface
- `DATA_W`, 8, data word width
- `ADDR_W`, 8, address width; depth is `DEPTH = 2**ADDR_W` (256)
- `AF_LEVEL`, 240, `almost_full` asserts when `usedw >= AF_LEVEL`; legal range 1..DEPTH
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wr_req`  in  1  write request from the producer
- `wr_data`  in  DATA_W  write data, sampled when a write is accepted
- `rd_req`  in  1  read request from the consumer
- `rd_data`  out  DATA_W  registered read data
- `rd_valid`  out  1  high for one cycle while `rd_data` holds a freshly read word
- `full`  out  1  FIFO holds DEPTH words
- `empty`  out  1  FIFO holds 0 words
- `almost_full`  out  1  `usedw >= AF_LEVEL`
- `usedw`  out  ADDR_W+1  number of stored words, 0..DEPTH
- `overflow`  out  1  one-cycle pulse: write requested while full
- `underflow`  out  1  one-cycle pulse: read requested while empty

## Operation
- Write accepted (`wr_acc`) = `wr_req & ~full`. Read accepted (`rd_acc`) = `rd_req & ~empty`. Both use the flag values registered at the start of the cycle.
- On `wr_acc`: `mem[wr_ptr] <= wr_data`; `wr_ptr` increments modulo DEPTH.
- On `rd_acc`: `rd_data <= mem[rd_ptr]`; `rd_ptr` increments modulo DEPTH; `rd_valid <= 1`. Otherwise `rd_valid <= 0` and `rd_data` holds its last value.
- `usedw` update: +1 for `wr_acc` only, −1 for `rd_acc` only, unchanged when both or neither occur. It never leaves 0..DEPTH.
- All flags are registered and derived from the next value of `usedw`: `full` = (DEPTH), `empty` = (0), `almost_full` = (>= AF_LEVEL). Flags are therefore valid in the same cycle as the `usedw` they describe.
- Simultaneous requests:
  - When full, only the read is accepted; `overflow` pulses and `usedw` goes DEPTH→DEPTH−1.
  - When empty, only the write is accepted; `underflow` pulses and `usedw` goes 0→1. Written data is not bypassed to `rd_data`.
  - Otherwise both are accepted and `usedw` is unchanged.
- `overflow <= wr_req & full`; `underflow <= rd_req & empty`. Rejected requests do not change memory, pointers or `rd_data`.
- Pointers are ADDR_W bits and wrap silently. full/empty come from `usedw`, not from comparing pointers.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `full`=0, `empty`=1, `almost_full`=0, `usedw`=0, `overflow`=0, `underflow`=0, both pointers 0. Memory contents are not reset.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). Stale memory is never read after reset, because `empty`=1.
- Read latency: for `rd_req` high at edge N, `rd_data`/`rd_valid` are valid after edge N+1 (one cycle).
- Write-to-read latency: a word written at edge N sets `empty`=0 after edge N. It can then be read at edge N+1, with data available after edge N+1.
- Back-to-back: one write and one read may be accepted every cycle, giving full throughput.
- `overflow`/`underflow` are high for exactly one cycle per offending request cycle. They are not sticky.

## Test plan
- Reset, then write 256 words 0x00..0xFF on consecutive cycles with `rd_req`=0:
  - `almost_full` rises the cycle `usedw`=240.
  - `full`=1 and `usedw`=256 after the 256th write.
  - `empty` drops after the first write.
- With the FIFO full, hold `wr_req`=1 with `wr_data`=0xAA for 3 cycles → `overflow` high for 3 cycles, `usedw` stays 256, and 0xAA is never read back.
- Drain with `rd_req`=1 for 258 cycles:
  - `rd_data` = 0x00..0xFF in order, each one cycle after its request, with `rd_valid` high for 256 cycles.
  - `empty`=1 after the last read.
  - `underflow` pulses on the 2 extra cycles.
- At `usedw`=10, assert `wr_req` and `rd_req` together for 20 cycles with an incrementing pattern → `usedw` stays 10 throughout and output order is preserved.
- Edge cases:
  - Empty FIFO, `wr_req`=`rd_req`=1 in the same cycle → only the write is accepted, `underflow` pulses once, `usedw`=1.
  - Full FIFO, same stimulus → only the read is accepted, `overflow` pulses once, `usedw`=255.
- Pointer wrap and reset mid-operation:
  - Stream 600 words with random `wr_req`/`rd_req` → scoreboard shows every accepted word read back in order across pointer wraps.
  - Pulse `rst_n` low for one cycle while `usedw`=37 → all outputs return to reset values, and a following read gives `underflow`=1 with `rd_valid`=0.
